inst_fetch_unit: RTL and testbench

- Requester side of the instruction ROM interface.
- Holds the program counter and drives chip-enable and address to the combinational instruction ROM.
- Captures each returned instruction word into a small FIFO and presents {pc, inst} pairs to decode with a valid/ready handshake.
- Handles stall and branch redirect from the pipeline control.

---
 rtl/inst_fetch_unit.sv | 126 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch front end.
// Drives the instruction ROM from the PC and queues {pc, inst} pairs for decode.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous reset, active-low
//   ce            ROM chip enable
//   addr          ROM byte address (the PC register)
//   inst          ROM data, valid in the same cycle as ce/addr
//   stall         pipeline stall, freezes fetch
//   branch_flag   single-cycle redirect request
//   branch_target redirect byte address
//   addr_misalign registered pulse: redirect target was not word aligned
//   id_valid      FIFO head valid toward decode
//   id_pc         PC of the head entry (0 when empty)
//   id_inst       instruction of the head entry (0 when empty)
//   id_ready      decode accepts the head this cycle
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ce,
   output logic [31:0] addr,
   input  logic [31:0] inst,
   input  logic        stall,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        addr_misalign,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   input  logic        id_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [31:0]   pc;
   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_inst [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic deq;
   logic enq;
   logic br;
   logic can_acc;

   assign addr     = pc;
   assign id_valid = (count != '0);
   assign id_pc    = id_valid ? mem_pc[rd_ptr]   : 32'h0;
   assign id_inst  = id_valid ? mem_inst[rd_ptr] : 32'h0;

   always_comb begin
      state_nxt = state;
      deq       = id_valid & id_ready;
      can_acc   = (count < FULL) | deq;
      // rst gating keeps the ROM disabled while reset is held
      ce        = rst & (state == FETCH) & ~stall & can_acc;
      br        = branch_flag & (state != IDLE);
      // the word read in a redirect cycle belongs to the old path
      enq       = ce & ~branch_flag;
      unique case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (stall) state_nxt = HOLD;
         HOLD:    if (!stall) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         addr_misalign <= 1'b0;
      end else begin
         state         <= state_nxt;
         addr_misalign <= br & (|branch_target[1:0]);
         if (br) begin
            pc     <= {branch_target[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (enq) begin
               pc     <= pc + PC_STEP;
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({enq, deq})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   // payload storage needs no reset: reads are masked by id_valid
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_pc[wr_ptr]   <= pc;
         mem_inst[wr_ptr] <= inst;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and random checks of inst_fetch_unit
// against a queue-based reference model.
module tb_inst_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] inst;
   logic        stall;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        addr_misalign;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_ready;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   bit          m_started;
   bit          m_frozen;
   bit          m_mis;
   bit          chk_en;
   int          n_cmp;
   int          n_bad;
   int          cyc;

   inst_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH),
      .PC_STEP  (32'd4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ce            (ce),
      .addr          (addr),
      .inst          (inst),
      .stall         (stall),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .addr_misalign (addr_misalign),
      .id_valid      (id_valid),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .id_ready      (id_ready)
   );

   // ROM content: word i holds i + 0x100
   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a >> 2) + 32'h100;
   endfunction

   assign inst = rom(addr);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h0;
      m_started = 1'b0;
      m_frozen  = 1'b0;
      m_mis     = 1'b0;
   endtask

   // one clock: drive at negedge, compare, then advance the model
   task automatic cycle(input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic rdy);
      logic e_ce;
      logic e_valid;
      logic deq;
      logic brx;
      ent_t hd;
      @(negedge clk);
      rst           = r;
      stall         = s;
      branch_flag   = b;
      branch_target = t;
      id_ready      = rdy;
      #1;
      cyc++;
      e_valid = (m_q.size() != 0);
      hd      = e_valid ? m_q[0] : '0;
      deq     = e_valid && rdy;
      e_ce    = r && m_started && !m_frozen && !s
                && ((m_q.size() < DEPTH) || deq);
      if (chk_en) begin
         chk("ce", ce, e_ce);
         chk("addr", addr, m_pc);
         chk("id_valid", id_valid, e_valid);
         chk("id_pc", id_pc, hd.pc);
         chk("id_inst", id_inst, hd.ins);
         chk("misalign", addr_misalign, m_mis);
      end
      if (!r) begin
         model_reset();
      end else begin
         brx   = b && m_started;
         m_mis = brx && (t[1:0] != 2'b00);
         if (brx) begin
            m_q.delete();
            m_pc = {t[31:2], 2'b00};
         end else begin
            if (deq) void'(m_q.pop_front());
            if (e_ce) begin
               m_q.push_back('{pc: m_pc, ins: rom(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
         if (m_started) m_frozen = s;
         else m_started = 1'b1;
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      cyc           = 0;
      chk_en        = 1'b0;
      rst           = 1'b0;
      stall         = 1'b0;
      branch_flag   = 1'b0;
      branch_target = 32'h0;
      id_ready      = 1'b0;
      model_reset();

      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk_en = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rst_valid", id_valid, 1'b0);
      chk("rst_addr", addr, 32'h0);

      // reset release, free-running stream
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("c1_ce", ce, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("c2_addr", addr, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("c3_pc", id_pc, 32'h0);
      chk("c3_inst", id_inst, 32'h100);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("c4_pc", id_pc, 32'h4);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // backpressure fills the FIFO, then drains
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("full_ce", ce, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // redirect with a full FIFO
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("br_valid", id_valid, 1'b0);
      chk("br_addr", addr, 32'h40);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("br_head", id_pc, 32'h40);

      // misaligned target
      cycle(1'b1, 1'b0, 1'b1, 32'h43, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("mis_flag", addr_misalign, 1'b1);
      chk("mis_addr", addr, 32'h40);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("mis_clr", addr_misalign, 1'b0);

      // stall mid-stream
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // redirect during stall
      cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("bs_addr", addr, 32'h80);
      chk("bs_ce", ce, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // PC wrap-around
      cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("wrap0", addr, 32'hFFFF_FFF8);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("wrap1", addr, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("wrap2", addr, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // reset mid-stream, redirect in IDLE is ignored
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
      chk("mrst_valid", id_valid, 1'b0);
      chk("mrst_addr", addr, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("idle_br", addr, 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tg;
         tg = $urandom();
         if ($urandom_range(1) == 0) tg = tg & 32'h0000_03FF;
         cycle(($urandom_range(63) != 0),
               ($urandom_range(4) == 0),
               ($urandom_range(7) == 0),
               tg,
               ($urandom_range(3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
